edge_cond_bank: RTL and testbench
=================================

// Module: edge_cond_bank
// PURPOSE
//  Multi-channel input conditioner: synchronises, debounces and edge-detects N_CH async inputs (keys, switches, ext strobes).
//  Per-channel mode selects which edges raise a one-cycle event pulse.
//  Sits between board pins and control FSMs; replaces ad-hoc single-bit pos/neg detector + delay chains.
// PARAMETERS
//  N_CH        4    number of independent channels
//  SYNC_STAGES 2    synchroniser flops per channel (>=2)
//  DEB_CYCLES  16   consecutive mismatching cycles before debounced level flips (>=1)
//  INIT_LEVEL  0    reset value of synchroniser, debounced level and edge history (all channels)
//  CNT_W       8    event counter width (used only with EDGE_CNT_EN)
// PORTS
//  clk        in   1        single clock, all logic posedge
//  rst        in   1        asynchronous, active-high reset
//  sig        in   N_CH     raw async inputs
//  mode       in   2*N_CH   per-channel edge select [2c+1:2c]: 00 none, 01 pos, 10 neg, 11 both
//  level      out  N_CH     debounced level
//  pos_pulse  out  N_CH     1-cycle pulse on debounced 0->1
//  neg_pulse  out  N_CH     1-cycle pulse on debounced 1->0
//  evt        out  N_CH     pos/neg pulse filtered by mode
//  evt_any    out  1        OR of evt
// BEHAVIOUR
//  - Reset (async assert, sync release): sync chain, level, edge history = INIT_LEVEL; deb counters = 0;
//    pulses/evt/evt_any = 0 during and first cycle after reset.
//  - Sync: sig passes SYNC_STAGES flops -> s.
//  - Debounce per channel: if s==level, cnt<=0. If s!=level and cnt==DEB_CYCLES-1: level<=s, cnt<=0; else cnt<=cnt+1.
//    Any single cycle of s==level during count restarts it (glitch rejection). cnt width = $clog2(DEB_CYCLES+1).
//  - Latency: sig stable change sampled at edge k -> level changes at edge k+SYNC_STAGES+DEB_CYCLES-1.
//  - Edge: prev<=level each cycle; pos_pulse=level&~prev, neg_pulse=~level&prev (same cycle level changes, exactly 1 cycle).
//  - evt[c] = (mode[2c]&pos_pulse[c]) | (mode[2c+1]&neg_pulse[c]); mode applied combinationally, no latch.
//  - Mode change mid-operation affects only pulses from that cycle on; never creates a pulse itself.
//  - Input held != INIT_LEVEL through reset release: produces normal edge after full latency (no suppression).
//  - Reset mid-count: count discarded, no pulse.
//  - Channels fully independent; simultaneous edges on all channels all reported same cycle.
// CONFIGURATION
//  EDGE_CNT_EN defined: adds ports cnt_clr in 1 (sync clear, all channels) and evt_cnt out CNT_W*N_CH.
//    evt_cnt[c] increments on evt[c], saturates at all-ones; reset 0; cnt_clr same cycle as evt -> 0 (clear wins).
//  EDGE_CNT_EN undefined: ports and counters absent; rest identical.
// STRUCTURE
//  Package edge_cond_pkg: mode localparams MODE_NONE/POS/NEG/BOTH (2'b00/01/10/11), mode_t typedef.
//  Sub-module edge_cond_ch: one channel (sync + debounce + edge + optional counter), generate-instanced N_CH times;
//  top only slices mode and ORs evt.
// TESTING
//  1. Reset with INIT_LEVEL=0, sig=0 -> all outputs 0; assert rst mid-sim -> outputs clear asynchronously.
//  2. DEB_CYCLES=4, SYNC_STAGES=2: sig 0->1 at edge 10, held -> level=1 and pos_pulse 1 cycle at edge 15.
//  3. Glitch: sig high 3 cycles then low, DEB_CYCLES=4 -> level stays 0, no pulses.
//  4. mode=01/10/11/00 on ch0..3, same press-release on all -> evt: ch0 press only, ch1 release only, ch2 both, ch3 none; evt_any on both.
//  5. EDGE_CNT_EN, CNT_W=2: 5 events -> evt_cnt=3 (saturated); cnt_clr with coincident evt -> 0.

Source files
------------

// File: rtl/edge_cond_pkg.sv
// Shared types and helpers for the edge conditioner bank.
package edge_cond_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_NONE = 2'b00;
    localparam mode_t MODE_POS  = 2'b01;
    localparam mode_t MODE_NEG  = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // Pick which debounced edges become an event for a given mode.
    function automatic logic edge_sel(input mode_t m, input logic pos, input logic neg);
        logic r;
        r = 1'b0;
        case (m)
            MODE_NONE: r = 1'b0;
            MODE_POS:  r = pos;
            MODE_NEG:  r = neg;
            MODE_BOTH: r = pos | neg;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/edge_cond_ch.sv
// One conditioner channel: synchroniser, debouncer, edge detector and,
// with EDGE_CNT_EN defined, a saturating event counter.
module edge_cond_ch
    import edge_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter bit          INIT_LEVEL  = 1'b0
`ifdef EDGE_CNT_EN
   ,parameter int unsigned CNT_W       = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  mode_t            mode,
    output logic             level,
    output logic             pos_pulse,
    output logic             neg_pulse,
    output logic             evt
`ifdef EDGE_CNT_EN
   ,input  logic             cnt_clr,
    output logic [CNT_W-1:0] evt_cnt
`endif
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DEB_W-1:0]       deb_cnt;
    logic                   prev;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain; oldest stage feeds the debouncer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
        end
    end

    // Debouncer: level follows s only after DEB_CYCLES unbroken mismatching cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= INIT_LEVEL;
            deb_cnt <= '0;
        end else if (s == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            level   <= s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Edge history: one-cycle delayed copy of the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= INIT_LEVEL;
        end else begin
            prev <= level;
        end
    end

    assign pos_pulse = level & ~prev;
    assign neg_pulse = ~level & prev;
    assign evt       = edge_sel(mode, pos_pulse, neg_pulse);

`ifdef EDGE_CNT_EN
    // Saturating event counter; a clear in the same cycle as an event wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt <= '0;
        end else if (evt && (evt_cnt != '1)) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/edge_cond_bank.sv
// Multi-channel input conditioner: N_CH independent sync/debounce/edge channels.
// Optional feature macro EDGE_CNT_EN adds cnt_clr and per-channel evt_cnt.
module edge_cond_bank
    import edge_cond_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter bit          INIT_LEVEL  = 1'b0
`ifdef EDGE_CNT_EN
   ,parameter int unsigned CNT_W       = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig,
    input  logic [2*N_CH-1:0]     mode,
    output logic [N_CH-1:0]       level,
    output logic [N_CH-1:0]       pos_pulse,
    output logic [N_CH-1:0]       neg_pulse,
    output logic [N_CH-1:0]       evt,
    output logic                  evt_any
`ifdef EDGE_CNT_EN
   ,input  logic                  cnt_clr,
    output logic [CNT_W*N_CH-1:0] evt_cnt
`endif
);

    // One conditioner per channel, each with its own two-bit mode slice.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        edge_cond_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .INIT_LEVEL  (INIT_LEVEL)
`ifdef EDGE_CNT_EN
           ,.CNT_W       (CNT_W)
`endif
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sig       (sig[c]),
            .mode      (mode_t'(mode[2*c +: 2])),
            .level     (level[c]),
            .pos_pulse (pos_pulse[c]),
            .neg_pulse (neg_pulse[c]),
            .evt       (evt[c])
`ifdef EDGE_CNT_EN
           ,.cnt_clr   (cnt_clr),
            .evt_cnt   (evt_cnt[c*CNT_W +: CNT_W])
`endif
        );
    end

    assign evt_any = |evt;

endmodule

// File: tb/tb_edge_cond_bank.sv
// Scoreboard bench for edge_cond_bank (SYNC_STAGES=2, DEB_CYCLES=4).
module tb_edge_cond_bank;
    import edge_cond_pkg::*;

    localparam int LAT = 2 + 4 - 1;  // sample edge -> level change edge

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig;
    logic [7:0] mode;
    logic [3:0] level, pos_pulse, neg_pulse, evt;
    logic       evt_any;
`ifdef EDGE_CNT_EN
    logic       cnt_clr;
    logic [7:0] evt_cnt;
`endif

    edge_cond_bank #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4),
        .INIT_LEVEL  (1'b0)
`ifdef EDGE_CNT_EN
       ,.CNT_W       (2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .mode      (mode),
        .level     (level),
        .pos_pulse (pos_pulse),
        .neg_pulse (neg_pulse),
        .evt       (evt),
        .evt_any   (evt_any)
`ifdef EDGE_CNT_EN
       ,.cnt_clr   (cnt_clr),
        .evt_cnt   (evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] level;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] evt;
        logic       any;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    task automatic push(input int c, input logic [3:0] l, input logic [3:0] p,
                        input logic [3:0] n, input logic [3:0] e, input logic a);
        exp_t x;
        x.cyc = c; x.level = l; x.pos = p; x.neg = n; x.evt = e; x.any = a;
        sb.push_back(x);
    endtask

    // Compare DUT outputs against every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc < cyc) begin
                check("missed_expectation", 32'(cyc), 32'(cur.cyc));
            end else begin
                check("level",     32'(level),     32'(cur.level));
                check("pos_pulse", 32'(pos_pulse), 32'(cur.pos));
                check("neg_pulse", 32'(neg_pulse), 32'(cur.neg));
                check("evt",       32'(evt),       32'(cur.evt));
                check("evt_any",   32'(evt_any),   32'(cur.any));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_level"}, 32'(level),     32'd0);
        check({tag, "_pos"},   32'(pos_pulse), 32'd0);
        check({tag, "_neg"},   32'(neg_pulse), 32'd0);
        check({tag, "_evt"},   32'(evt),       32'd0);
        check({tag, "_any"},   32'(evt_any),   32'd0);
    endtask

    logic [7:0] mode_nominal;

    initial begin
        int k;
        mode_nominal = {MODE_NONE, MODE_BOTH, MODE_NEG, MODE_POS};
        rst  = 1'b1;
        sig  = 4'b0000;
        mode = mode_nominal;
`ifdef EDGE_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) tick();
        check_cleared("in_reset");

        // Reset release: outputs stay quiet on the first cycles after.
        rst = 1'b0;
        push(cyc + 1, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        push(cyc + 2, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        drain();

        // Single press on ch0 (mode pos).
        tick(); k = cyc + 1; sig = 4'b0001;
        push(k + LAT - 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        push(k + LAT,     4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
        push(k + LAT + 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drain();

        // Release ch0: neg pulse, but mode pos filters the event.
        tick(); k = cyc + 1; sig = 4'b0000;
        push(k + LAT - 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        push(k + LAT,     4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        push(k + LAT + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drain();

        // Three-cycle glitch on ch1 is rejected.
        tick(); k = cyc + 1; sig = 4'b0010;
        for (int i = 0; i < 10; i++) push(k + i, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        repeat (3) tick();
        sig = 4'b0000;
        drain();

        // Simultaneous press on all channels.
        tick(); k = cyc + 1; sig = 4'b1111;
        push(k + LAT - 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        push(k + LAT,     4'b1111, 4'b1111, 4'b0000, 4'b0101, 1'b1);
        push(k + LAT + 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drain();

        // Mode change with steady levels creates no event.
        tick(); mode = 8'hFF;
        push(cyc + 1, 4'b1111, 4'b0, 4'b0, 4'b0, 1'b0);
        push(cyc + 2, 4'b1111, 4'b0, 4'b0, 4'b0, 1'b0);
        drain();
        mode = mode_nominal;

        // Simultaneous release on all channels.
        tick(); k = cyc + 1; sig = 4'b0000;
        push(k + LAT,     4'b0000, 4'b0000, 4'b1111, 4'b0110, 1'b1);
        push(k + LAT + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drain();

        // Press again, then reset asynchronously while levels are high.
        tick(); k = cyc + 1; sig = 4'b1111;
        push(k + LAT, 4'b1111, 4'b1111, 4'b0000, 4'b0101, 1'b1);
        drain();
        tick(); rst = 1'b1; #1;
        check_cleared("async_rst");
        repeat (2) tick();

        // Input held high through reset release yields a normal edge.
        rst = 1'b0; k = cyc + 1;
        push(cyc + 1,     4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        push(k + LAT - 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        push(k + LAT,     4'b1111, 4'b1111, 4'b0000, 4'b0101, 1'b1);
        drain();

        // Reset in the middle of a release count discards it.
        tick(); sig = 4'b0000;
        repeat (3) tick();
        rst = 1'b1; #1;
        check_cleared("midcount_rst");
        tick(); rst = 1'b0;
        for (int i = 1; i <= 10; i++) push(cyc + i, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        drain();

`ifdef EDGE_CNT_EN
        // Five ch0 presses saturate a 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            tick(); sig = 4'b0001;
            repeat (LAT + 2) tick();
            sig = 4'b0000;
            repeat (LAT + 2) tick();
        end
        check("cnt_sat_ch0",  32'(evt_cnt[1:0]), 32'd3);
        check("cnt_idle_ch1", 32'(evt_cnt[3:2]), 32'd0);

        // Clear coincident with an event wins.
        tick(); k = cyc + 1; sig = 4'b0001;
        while (cyc < k + LAT) tick();
        check("evt_before_clr", 32'(evt[0]), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr_wins", 32'(evt_cnt[1:0]), 32'd0);
        sig = 4'b0000;
        repeat (LAT + 2) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
